// File: rtl/niosii_esercitazione_irq_collector_pkg.sv
// ============================================================================
// Module   : niosii_esercitazione_irq_pkg
// Brief    : Register map constants and helpers shared by the IRQ collector.
// Revision : 1.0
// ============================================================================
`default_nettype none

package niosii_esercitazione_irq_pkg;

    localparam logic [2:0] ADDR_PENDING   = 3'd0;
    localparam logic [2:0] ADDR_MASK      = 3'd1;
    localparam logic [2:0] ADDR_MODE      = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE_ID = 3'd3;
    localparam logic [2:0] ADDR_RAW       = 3'd4;
    localparam logic [2:0] ADDR_OVERFLOW  = 3'd5;
    localparam logic [2:0] ADDR_FORCE     = 3'd6;

    localparam int ACTIVE_VALID_BIT = 15;
    localparam int MAX_SRC          = 16;
    localparam int DATA_W           = 16;

    // Index of the lowest set bit, 0 when none is set.
    function automatic logic [3:0] lowest_index(input logic [MAX_SRC-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/niosii_esercitazione_irq_sync_edge.sv
// ============================================================================
// Module   : niosii_esercitazione_irq_sync_edge
// Brief    : Per-source input synchronizer with rising-edge detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module niosii_esercitazione_irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic irq_i,
    input  logic resync_strobe_i,
    output logic s_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= irq_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= s_o;
        end
    end

    assign s_o = sync_q[SYNC_STAGES-1];

    // prev already follows s every cycle, so a resync only has to hide the
    // edge seen in the strobe cycle itself.
    assign rise_o = s_o & ~prev_q & ~resync_strobe_i;

endmodule

`default_nettype wire

// File: rtl/niosii_esercitazione_irq_collector.sv
// ============================================================================
// Module   : niosii_esercitazione_irq_collector
// Brief    : Avalon-MM interrupt collector merging NUM_SRC lines into one IRQ.
// Revision : 1.0
// ============================================================================
`default_nettype none

module niosii_esercitazione_irq_collector
    import niosii_esercitazione_irq_pkg::*;
#(
    parameter int                 NUM_SRC     = 4,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [MAX_SRC-1:0] MODE_RESET  = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [DATA_W-1:0]  writedata,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic [DATA_W-1:0]  readdata,
    output logic               irq
);

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] overflow_q, overflow_d;
    logic [NUM_SRC-1:0] mask_q, mode_q;
    logic [DATA_W-1:0]  readdata_q, readdata_d;
    logic               irq_q, irq_d;

    logic [NUM_SRC-1:0] w_s, w_rise, w_mode_chg, w_wdata, w_active;
    logic               w_wr;
    logic               w_wr_pend, w_wr_mask, w_wr_mode, w_wr_ovf, w_wr_force;
    logic [MAX_SRC-1:0] w_pend_ext, w_mask_ext, w_mode_ext, w_ovf_ext, w_raw_ext, w_act_ext;
    logic               w_unused_wdata;

    assign w_wdata        = writedata[NUM_SRC-1:0];
    assign w_unused_wdata = ^writedata;

    assign w_wr       = chipselect & ~write_n;
    assign w_wr_pend  = w_wr & (address == ADDR_PENDING);
    assign w_wr_mask  = w_wr & (address == ADDR_MASK);
    assign w_wr_mode  = w_wr & (address == ADDR_MODE);
    assign w_wr_ovf   = w_wr & (address == ADDR_OVERFLOW);
    assign w_wr_force = w_wr & (address == ADDR_FORCE);

    assign w_mode_chg = w_wr_mode ? (w_wdata ^ mode_q) : '0;
    assign w_active   = pending_q & mask_q;

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
        niosii_esercitazione_irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .clk             (clk),
            .reset_n         (reset_n),
            .irq_i           (irq_in[n]),
            .resync_strobe_i (w_mode_chg[n]),
            .s_o             (w_s[n]),
            .rise_o          (w_rise[n])
        );
    end

    // A mode change wipes the source's state and outranks any set.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        for (int n = 0; n < NUM_SRC; n++) begin
            if (w_mode_chg[n]) begin
                pending_d[n]  = 1'b0;
                overflow_d[n] = 1'b0;
            end else if (mode_q[n]) begin
                if (w_rise[n] | (w_wr_force & w_wdata[n])) begin
                    pending_d[n] = 1'b1;
                end else if (w_wr_pend & w_wdata[n]) begin
                    pending_d[n] = 1'b0;
                end
                if (w_rise[n] & pending_q[n] & ~(w_wr_pend & w_wdata[n])) begin
                    overflow_d[n] = 1'b1;
                end else if (w_wr_ovf & w_wdata[n]) begin
                    overflow_d[n] = 1'b0;
                end
            end else begin
                pending_d[n] = w_s[n];
            end
        end
    end

    always_comb begin
        w_pend_ext = '0;
        w_mask_ext = '0;
        w_mode_ext = '0;
        w_ovf_ext  = '0;
        w_raw_ext  = '0;
        w_act_ext  = '0;
        w_pend_ext[NUM_SRC-1:0] = pending_q;
        w_mask_ext[NUM_SRC-1:0] = mask_q;
        w_mode_ext[NUM_SRC-1:0] = mode_q;
        w_ovf_ext[NUM_SRC-1:0]  = overflow_q;
        w_raw_ext[NUM_SRC-1:0]  = w_s;
        w_act_ext[NUM_SRC-1:0]  = w_active;

        readdata_d = '0;
        case (address)
            ADDR_PENDING:   readdata_d = w_pend_ext;
            ADDR_MASK:      readdata_d = w_mask_ext;
            ADDR_MODE:      readdata_d = w_mode_ext;
            ADDR_ACTIVE_ID: begin
                readdata_d[ACTIVE_VALID_BIT] = |w_active;
                readdata_d[3:0]              = lowest_index(w_act_ext);
            end
            ADDR_RAW:       readdata_d = w_raw_ext;
            ADDR_OVERFLOW:  readdata_d = w_ovf_ext;
            default:        readdata_d = '0;
        endcase

        irq_d = |w_active;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            overflow_q <= '0;
            mask_q     <= '0;
            mode_q     <= MODE_RESET[NUM_SRC-1:0];
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            if (w_wr_mask) mask_q <= w_wdata;
            if (w_wr_mode) mode_q <= w_wdata;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_niosii_esercitazione_irq_collector.sv
// ============================================================================
// Module   : tb_niosii_esercitazione_irq_collector
// Brief    : Directed and randomized bench for the IRQ collector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_niosii_esercitazione_irq_collector;

    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = 16'd0;
    logic [3:0]  irq_in = 4'd0;
    logic [15:0] readdata;
    logic        irq;

    int checks = 0;
    int failures = 0;

    // Reference state: delay line for the synchronizer, plus register file.
    logic [3:0]  m_sq [SS];
    logic [3:0]  m_prev, m_pend, m_mask, m_mode, m_ovf;
    logic [15:0] m_rd;
    logic        m_irq;

    niosii_esercitazione_irq_collector #(
        .NUM_SRC     (4),
        .SYNC_STAGES (SS),
        .MODE_RESET  (16'h0000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .irq_in     (irq_in),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_sq[i] = 4'd0;
        m_prev = 4'd0; m_pend = 4'd0; m_mask = 4'd0; m_mode = 4'd0; m_ovf = 4'd0;
        m_rd = 16'd0; m_irq = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] s, wd4, chg, rise, act, np, no, id;
        logic       wr, do_set, do_clr;
        s    = m_sq[SS-1];
        wd4  = writedata[3:0];
        wr   = chipselect && !write_n;
        chg  = (wr && address == 3'd2) ? (wd4 ^ m_mode) : 4'd0;
        rise = s & ~m_prev;
        act  = m_pend & m_mask;
        id   = 4'd0;
        for (int n = 3; n >= 0; n--) if (act[n]) id = 4'(n);
        case (address)
            3'd0: m_rd = {12'd0, m_pend};
            3'd1: m_rd = {12'd0, m_mask};
            3'd2: m_rd = {12'd0, m_mode};
            3'd3: m_rd = {(act != 4'd0), 11'd0, id};
            3'd4: m_rd = {12'd0, s};
            3'd5: m_rd = {12'd0, m_ovf};
            default: m_rd = 16'd0;
        endcase
        m_irq = (act != 4'd0);
        np = m_pend;
        no = m_ovf;
        for (int n = 0; n < 4; n++) begin
            if (chg[n]) begin
                np[n] = 1'b0;
                no[n] = 1'b0;
            end else if (m_mode[n]) begin
                do_clr = wr && address == 3'd0 && wd4[n];
                do_set = rise[n] || (wr && address == 3'd6 && wd4[n]);
                if (do_set) np[n] = 1'b1;
                else if (do_clr) np[n] = 1'b0;
                if (rise[n] && m_pend[n] && !do_clr) no[n] = 1'b1;
                else if (wr && address == 3'd5 && wd4[n]) no[n] = 1'b0;
            end else begin
                np[n] = s[n];
            end
        end
        m_pend = np;
        m_ovf  = no;
        if (wr && address == 3'd1) m_mask = wd4;
        if (wr && address == 3'd2) m_mode = wd4;
        m_prev = s;
        for (int i = SS - 1; i > 0; i--) m_sq[i] = m_sq[i-1];
        m_sq[0] = irq_in;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        cycle();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_at(input logic [2:0] a);
        address = a;
        cycle();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = 3'd0; writedata = 16'd0; irq_in = 4'd0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int a = 0; a < 8; a++) begin
            rd_at(3'(a));
            checks++;
            if (readdata !== 16'd0 || irq !== 1'b0) begin
                failures++;
                $display("FAIL reset_read addr=%0d readdata=%h irq=%b expected 0000/0", a, readdata, irq);
            end
        end
    endtask

    task automatic test_edge_latency();
        do_reset();
        wr(3'd2, 16'h1);
        wr(3'd1, 16'h1);
        address = 3'd0;
        irq_in[0] = 1'b1;
        cycles(3);
        checks++;
        if (irq !== 1'b0 || readdata !== 16'h0) begin
            failures++;
            $display("FAIL edge_early irq=%b readdata=%h expected 0/0000", irq, readdata);
        end
        cycle();
        checks++;
        if (irq !== 1'b1 || readdata !== 16'h1) begin
            failures++;
            $display("FAIL edge_latency irq=%b readdata=%h expected 1/0001", irq, readdata);
        end
        rd_at(3'd3);
        checks++;
        if (readdata !== 16'h8000) begin
            failures++;
            $display("FAIL edge_active_id readdata=%h expected 8000", readdata);
        end
        wr(3'd0, 16'h1);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL w1c_irq_hold irq=%b expected 1", irq);
        end
        cycle();
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL w1c_irq_fall irq=%b expected 0", irq);
        end
        irq_in = 4'd0;
        cycles(3);
    endtask

    task automatic test_edge_overflow();
        do_reset();
        wr(3'd2, 16'h4);
        wr(3'd1, 16'h4);
        irq_in[2] = 1'b1; cycles(4);
        irq_in[2] = 1'b0; cycles(3);
        irq_in[2] = 1'b1; cycles(4);
        rd_at(3'd0);
        rd_at(3'd5);
        checks++;
        if (readdata !== 16'h4) begin
            failures++;
            $display("FAIL overflow_set readdata=%h expected 0004", readdata);
        end
        irq_in[2] = 1'b0; cycles(4);
        irq_in[2] = 1'b1; cycles(2);
        wr(3'd0, 16'h4);
        rd_at(3'd0);
        rd_at(3'd0);
        checks++;
        if (readdata !== 16'h4) begin
            failures++;
            $display("FAIL set_beats_w1c readdata=%h expected 0004", readdata);
        end
        wr(3'd5, 16'h4);
        rd_at(3'd5);
        rd_at(3'd5);
        checks++;
        if (readdata !== 16'h0) begin
            failures++;
            $display("FAIL overflow_w1c readdata=%h expected 0000", readdata);
        end
        irq_in = 4'd0;
        cycles(3);
    endtask

    task automatic test_level();
        do_reset();
        wr(3'd1, 16'h2);
        irq_in[1] = 1'b1;
        cycles(5);
        rd_at(3'd0);
        checks++;
        if (readdata !== 16'h2 || irq !== 1'b1) begin
            failures++;
            $display("FAIL level_pending readdata=%h irq=%b expected 0002/1", readdata, irq);
        end
        wr(3'd0, 16'h2);
        rd_at(3'd0);
        rd_at(3'd0);
        checks++;
        if (readdata !== 16'h2) begin
            failures++;
            $display("FAIL level_w1c_ignored readdata=%h expected 0002", readdata);
        end
        irq_in[1] = 1'b0;
        cycles(3);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL level_irq_hold irq=%b expected 1", irq);
        end
        cycle();
        checks++;
        if (readdata !== 16'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL level_drop readdata=%h irq=%b expected 0000/0", readdata, irq);
        end
    endtask

    task automatic test_priority();
        do_reset();
        irq_in = 4'b1010;
        cycles(4);
        wr(3'd1, 16'hA);
        rd_at(3'd3);
        checks++;
        if (readdata !== 16'h8001) begin
            failures++;
            $display("FAIL prio_mask_a readdata=%h expected 8001", readdata);
        end
        wr(3'd1, 16'h8);
        rd_at(3'd3);
        checks++;
        if (readdata !== 16'h8003) begin
            failures++;
            $display("FAIL prio_mask_8 readdata=%h expected 8003", readdata);
        end
        wr(3'd1, 16'h0);
        rd_at(3'd3);
        checks++;
        if (readdata !== 16'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL prio_mask_0 readdata=%h irq=%b expected 0000/0", readdata, irq);
        end
        irq_in = 4'd0;
        cycles(3);
    endtask

    task automatic test_force_mode();
        do_reset();
        wr(3'd2, 16'h1);
        wr(3'd6, 16'h5);
        rd_at(3'd0);
        checks++;
        if (readdata !== 16'h1) begin
            failures++;
            $display("FAIL force readdata=%h expected 0001", readdata);
        end
        irq_in[0] = 1'b1;
        cycles(4);
        wr(3'd2, 16'h0);
        rd_at(3'd5);
        rd_at(3'd5);
        checks++;
        if (readdata !== 16'h0) begin
            failures++;
            $display("FAIL mode_switch_overflow readdata=%h expected 0000", readdata);
        end
        wr(3'd2, 16'h1);
        rd_at(3'd0);
        rd_at(3'd0);
        checks++;
        if (readdata !== 16'h0) begin
            failures++;
            $display("FAIL mode_switch_no_edge readdata=%h expected 0000", readdata);
        end
    endtask

    task automatic test_async_reset();
        wr(3'd6, 16'h1);
        wr(3'd1, 16'h1);
        rd_at(3'd0);
        rd_at(3'd0);
        checks++;
        if (irq !== 1'b1 || readdata !== 16'h1) begin
            failures++;
            $display("FAIL pre_reset irq=%b readdata=%h expected 1/0001", irq, readdata);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0 || readdata !== 16'h0) begin
            failures++;
            $display("FAIL async_reset irq=%b readdata=%h expected 0/0000", irq, readdata);
        end
        irq_in = 4'd0;
        #1;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        model_step();
        model_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            address    = 3'($urandom_range(0, 7));
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = ($urandom_range(0, 9) > 2);
            writedata  = 16'($urandom);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) irq_in[b] = ~irq_in[b];
            end
            cycle();
            checks++;
            if (readdata !== m_rd || irq !== m_irq) begin
                failures++;
                $display("FAIL random_cycle%0d readdata=%h irq=%b expected %h/%b", i, readdata, irq, m_rd, m_irq);
            end
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_edge_latency();
        test_edge_overflow();
        test_level();
        test_priority();
        test_force_mode();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
